// File: rtl/multichunk_adder_ctrl.sv
// Sequential WIDTH-bit adder that processes one CHUNK-bit slice per clock.
// Optional macro OVERFLOW_DETECT_EN adds the signed-overflow output OVF.
module multichunk_adder_ctrl #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
`ifdef OVERFLOW_DETECT_EN
   output logic             OVF,
`endif
   output logic             busy,
   output logic             done
);

   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [IDXW-1:0]  idx_q, idx_d;
`ifdef OVERFLOW_DETECT_EN
   logic             ovf_q, ovf_d;
`endif

   logic [CHUNK-1:0] a_chunk_s;
   logic [CHUNK-1:0] b_chunk_s;
   logic [CHUNK:0]   csum_s;

   // Mux-free slice select: OR together every slice gated by its index match.
   always_comb begin
      a_chunk_s = '0;
      b_chunk_s = '0;
      for (int i = 0; i < N; i++) begin
         a_chunk_s = a_chunk_s | (a_q[i*CHUNK +: CHUNK] & {CHUNK{idx_q == IDXW'(i)}});
         b_chunk_s = b_chunk_s | (b_q[i*CHUNK +: CHUNK] & {CHUNK{idx_q == IDXW'(i)}});
      end
      csum_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_q};
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
`ifdef OVERFLOW_DETECT_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               carry_d = Cin;
               s_d     = '0;
               cout_d  = 1'b0;
               idx_d   = '0;
`ifdef OVERFLOW_DETECT_EN
               ovf_d   = 1'b0;
`endif
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < N; i++) begin
               s_d[i*CHUNK +: CHUNK] = (idx_q == IDXW'(i)) ? csum_s[CHUNK-1:0]
                                                         : s_q[i*CHUNK +: CHUNK];
            end
            carry_d = csum_s[CHUNK];
            if (idx_q == IDX_LAST) begin
               cout_d  = csum_s[CHUNK];
`ifdef OVERFLOW_DETECT_EN
               // Same-sign operands producing an opposite-sign result.
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (csum_s[CHUNK-1] != a_q[WIDTH-1]);
`endif
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + IDXW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
`ifdef OVERFLOW_DETECT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
`ifdef OVERFLOW_DETECT_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign S    = s_q;
   assign Cout = cout_q;
   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
`ifdef OVERFLOW_DETECT_EN
   assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_multichunk_adder_ctrl.sv
// Randomized and directed bench for multichunk_adder_ctrl against a
// cycle-count reference model (honours OVERFLOW_DETECT_EN if defined).
module tb_multichunk_adder_ctrl;

   localparam int WIDTH = 64;
   localparam int CHUNK = 16;
   localparam int N     = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start;
   logic [WIDTH-1:0] A, B;
   logic             Cin;
   logic [WIDTH-1:0] S;
   logic             Cout, busy, done;
`ifdef OVERFLOW_DETECT_EN
   logic             OVF;
`endif

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   multichunk_adder_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
      .S(S), .Cout(Cout),
`ifdef OVERFLOW_DETECT_EN
      .OVF(OVF),
`endif
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: a countdown of remaining chunk cycles and a result
   // computed with plain wide arithmetic at accept time.
   logic [WIDTH:0]   m_full;
   logic             m_full_ovf;
   int               m_cnt;
   bit               m_done;
   logic [WIDTH:0]   m_pend;
   logic             m_povf;
   logic [WIDTH-1:0] m_s;
   logic             m_c, m_ovf;

   assign m_full     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
   assign m_full_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (m_full[WIDTH-1] != A[WIDTH-1]);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt <= 0; m_done <= 1'b0; m_s <= '0; m_c <= 1'b0; m_ovf <= 1'b0;
         m_pend <= '0; m_povf <= 1'b0;
      end else if (m_cnt == 0 && start) begin
         m_cnt <= N; m_done <= 1'b0; m_pend <= m_full; m_povf <= m_full_ovf;
         m_s <= '0; m_c <= 1'b0; m_ovf <= 1'b0;
      end else if (m_cnt == 1) begin
         m_cnt <= 0; m_done <= 1'b1;
         m_s <= m_pend[WIDTH-1:0]; m_c <= m_pend[WIDTH]; m_ovf <= m_povf;
      end else if (m_cnt > 1) begin
         m_cnt <= m_cnt - 1;
      end else begin
         m_done <= 1'b0;
      end
   end

   task automatic check(input string nm, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Per-cycle compare against the model.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("cyc_busy", {{WIDTH{1'b0}}, busy}, {{WIDTH{1'b0}}, (m_cnt > 0)});
         check("cyc_done", {{WIDTH{1'b0}}, done}, {{WIDTH{1'b0}}, m_done});
         if (m_cnt == 0) begin
            check("cyc_sum", {Cout, S}, {m_c, m_s});
`ifdef OVERFLOW_DETECT_EN
            check("cyc_ovf", {{WIDTH{1'b0}}, OVF}, {{WIDTH{1'b0}}, m_ovf});
`endif
         end
      end
   end

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (done) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   // One transaction from a negedge; operands are scrambled and start is
   // pulsed while running to show both are ignored.
   task automatic run_one(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic [WIDTH-1:0] es, input logic ec,
                          input logic chk_ovf, input logic eovf);
      int busy_cnt;
      bit seen;
      A = a; B = b; Cin = cin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = '1; B = '1; Cin = 1'b1;
      busy_cnt = 0;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
         if (k == 1) start = 1'b1;
         if (k == 2) start = 1'b0;
         @(negedge clk);
      end
      check({nm, "_done_seen"}, {{WIDTH{1'b0}}, seen}, {{WIDTH{1'b0}}, 1'b1});
      check({nm, "_busy_cycles"}, WIDTH'(busy_cnt) + 65'd0, 65'd4);
      check({nm, "_sum"}, {Cout, S}, {ec, es});
`ifdef OVERFLOW_DETECT_EN
      if (chk_ovf) check({nm, "_ovf"}, {{WIDTH{1'b0}}, OVF}, {{WIDTH{1'b0}}, eovf});
`else
      if (chk_ovf && eovf) check({nm, "_ovf_unused"}, 65'd0, 65'd0);
`endif
      @(negedge clk);
      check({nm, "_done_pulse"}, {{WIDTH{1'b0}}, done}, 65'd0);
      check({nm, "_hold"}, {Cout, S}, {ec, es});
   endtask

   initial begin
      bit ok;
      int t1, t2;
      start = 1'b0; A = '0; B = '0; Cin = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      check("reset_state", {busy, done, Cout, S[61:0]}, 65'd0);
      @(negedge clk);
      rst = 1'b0;

      run_one("all_ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0);
      run_one("cross_chunk", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
      run_one("mid_run_change", 64'd5, 64'd6, 1'b0, 64'd11, 1'b0, 1'b0, 1'b0);

      // Back-to-back with start held high.
      A = 64'd1; B = 64'd2; Cin = 1'b0; start = 1'b1;
      @(negedge clk);
      A = 64'd3; B = 64'd4;
      wait_done(ok);
      check("b2b_first_seen", {{WIDTH{1'b0}}, ok}, 65'd1);
      t1 = cyc;
      check("b2b_first_sum", {Cout, S}, 65'd3);
      @(negedge clk);
      start = 1'b0;
      wait_done(ok);
      check("b2b_second_seen", {{WIDTH{1'b0}}, ok}, 65'd1);
      t2 = cyc;
      check("b2b_gap", 65'(t2 - t1), 65'd5);
      check("b2b_second_sum", {Cout, S}, 65'd7);
      @(negedge clk);

      // Asynchronous reset in the middle of a run.
      A = 64'd5; B = 64'd6; Cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("partial_sum", {Cout, S}, 65'd11);
      #1 rst = 1'b1;
      #1 check("abort_state", {busy, done, Cout, S[61:0]}, 65'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check("no_done_after_abort", {{WIDTH{1'b0}}, done}, 65'd0);
         @(negedge clk);
      end

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run_one("first_after_reset", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
              64'h2222_2222_2222_2212, 1'b0, 1'b0, 1'b0);

      run_one("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
      run_one("ovf_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);

      // Randomized traffic checked by the per-cycle compare.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) != 0);
         Cin   = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: A = '1;
            1: A = 64'd0;
            2: A = 64'($urandom_range(0, 255));
            default: A = {$urandom, $urandom};
         endcase
         case ($urandom_range(0, 3))
            0: B = '1;
            1: B = 64'h8000_0000_0000_0000;
            2: B = 64'($urandom_range(0, 255));
            default: B = {$urandom, $urandom};
         endcase
         if ($urandom_range(0, 60) == 0) begin
            #2 rst = 1'b1;
            #2 rst = 1'b0;
         end
      end
      start = 1'b0;
      repeat (8) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
